i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- Playback-side counterpart of the recording path: reads 16-bit samples from the external SRAM over the address window [i_start_addr, i_end_addr) filled by the recorder.
- Serialises each sample MSB-first on DACDAT in I2S format, using the BCLK/DACLRC clocks supplied by the codec (codec is master).
- Each sample is sent on both left and right channels (mono duplicate).
- Supports start, pause/resume, stop, and reports playing/done status to the top-level controller.

Parameters:
- DATA_W, 16, sample width and shift length per channel
- ADDR_W, 20, SRAM word-address width

Ports:
- i_BCLK  in  1  bit clock from codec; all state updates on its falling edge
- i_rst  in  1  asynchronous reset, active-high
- i_start  in  1  begin playback from i_start_addr (level, sampled each cycle)
- i_pause  in  1  toggle pause/resume (one-cycle pulse)
- i_stop  in  1  abort playback
- i_DACLRC  in  1  channel clock from codec (0 = left, 1 = right)
- i_start_addr  in  ADDR_W  first sample address
- i_end_addr  in  ADDR_W  one past last sample (modulo 2^ADDR_W)
- i_sram_data  in  DATA_W  SRAM read data, valid combinationally for o_sram_addr
- o_sram_addr  out  ADDR_W  read address
- o_sram_we  out  1  write enable, active-low; constant 1
- o_sram_ce, o_sram_oe, o_sram_lb, o_sram_ub  out  1 each  active-low; 0 while reading, 1 in IDLE
- o_DACDAT  out  1  serial audio data
- o_playing  out  1  high in any non-IDLE, non-PAUSED state
- o_done  out  1  one-cycle pulse when the last sample's right channel completes

Behaviour:
- Reset (async, i_rst=1) values:
  - state IDLE; o_DACDAT 0; o_sram_addr 0
  - ce/oe/lb/ub 1; we 1
  - o_playing 0; o_done 0
  - bit counter 0; shift register 0; lrc_prev 1
- LRC edge detection: lrc_prev is registered from i_DACLRC every cycle.
  - fall = lrc_prev & ~i_DACLRC
  - rise = ~lrc_prev & i_DACLRC
- States: IDLE, SYNC, SEND_L, WAIT_R, SEND_R, ADVANCE, PAUSED.
- IDLE:
  - o_DACDAT 0.
  - On i_start: load addr <= i_start_addr. If i_start_addr == i_end_addr, pulse o_done and stay IDLE. Otherwise go to SYNC.
- SYNC: wait for fall.
  - On fall: shift <= i_sram_data, o_DACDAT <= i_sram_data[DATA_W-1], cnt <= 1, go to SEND_L.
  - The SRAM is enabled in SYNC so data is valid at that edge.
- SEND_L:
  - Each cycle: o_DACDAT <= shift[DATA_W-1-cnt], cnt+1.
  - After cnt reaches DATA_W: o_DACDAT <= 0, go to WAIT_R.
  - Left channel therefore carries bits 15..0 on 16 consecutive cycles starting at the detection edge.
- WAIT_R:
  - o_DACDAT 0.
  - On rise: o_DACDAT <= shift[DATA_W-1], cnt <= 1, go to SEND_R.
- SEND_R: same shifting as SEND_L. After the last bit, go to ADVANCE.
- ADVANCE (1 cycle):
  - addr <= addr+1, mod 2^ADDR_W (wraps 0xFFFFF -> 0).
  - If addr+1 == i_end_addr: pulse o_done, go to IDLE.
  - Else if pause pending: go to PAUSED.
  - Else: go to SYNC.
- Pause:
  - An i_pause pulse in any playing state sets pause_pending. It takes effect only at ADVANCE, so no partial frame is emitted.
  - In PAUSED: o_DACDAT 0, SRAM disabled (ce/oe 1), addr held.
  - An i_pause pulse in PAUSED clears pending and goes to SYNC.
  - An i_pause pulse in IDLE is ignored.
- Stop:
  - i_stop in any state goes to IDLE next cycle; o_DACDAT 0; pause_pending cleared; no o_done.
  - i_stop has priority over i_start and i_pause in the same cycle.
- Unexpected LRC edges:
  - A fall while in SEND_R/WAIT_R, or a rise while in SEND_L: the frame is truncated, state goes to SYNC, addr unchanged (sample replayed).
- End address: i_end_addr is sampled each ADVANCE. Changing it mid-play takes effect at the next ADVANCE.
- Idle pins: in IDLE, SRAM controls are driven 1 (not tri-stated); bus arbitration is done at top level.

Test Plan:
- Reset mid-SEND_L (cnt=7) -> next edge all outputs at reset values, o_DACDAT 0, state IDLE.
- start_addr=0, end_addr=2, SRAM[0]=0xA5C3, SRAM[1]=0x8001, LRC period 64 BCLK -> DACDAT left and right frames show 1010010111000011 then 1000000000000001 beginning at each LRC edge; o_done pulses after frame 2 right bit 0; o_sram_addr ends at 2.
- start_addr=0xFFFFF, end_addr=0x00001 -> plays addr 0xFFFFF then 0x00000, wraps correctly, o_done after 2 samples.
- i_pause pulse during sample 3's left channel -> sample 3 completes both channels, then DACDAT stays 0 and addr=4 for 200 cycles; second pause pulse -> resumes with sample 4 at the next LRC fall.
- i_stop and i_start asserted in the same cycle during SEND_R -> IDLE, DACDAT 0, o_done stays 0.
- start_addr == end_addr=0x100 -> o_done pulses one cycle after i_start, state stays IDLE, no SRAM enable.

Source files
------------

// File: rtl/i2s_transmitter.sv
// I2S playback: reads 16-bit mono samples from SRAM and sends each on left and right; BCLK/DACLRC from codec.
// Updates on BCLK falling edge; bit 15 goes out on the edge that detects the LRC edge; no backpressure, the codec paces it.
module i2s_transmitter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20
) (
   input  logic              i_BCLK,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic              i_DACLRC,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_we,
   output logic              o_sram_ce,
   output logic              o_sram_oe,
   output logic              o_sram_lb,
   output logic              o_sram_ub,
   output logic              o_DACDAT,
   output logic              o_playing,
   output logic              o_done
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DATA_W);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, SYNC, SEND_L, WAIT_R, SEND_R, ADVANCE, PAUSED} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shift;
   logic              lrc_prev;
   logic              pause_pend;
   logic              run;
   logic              fall;
   logic              rise;
   logic              last_bit;
   logic [IDX_W-1:0]  bit_idx;
   logic [ADDR_W-1:0] addr_nxt;

   assign fall     = lrc_prev & ~i_DACLRC;
   assign rise     = ~lrc_prev & i_DACLRC;
   assign last_bit = (cnt == CNT_END);
   assign bit_idx  = IDX_MAX - cnt[IDX_W-1:0];
   assign addr_nxt = o_sram_addr + 1'b1;

   // run is high exactly in the reading states, so SRAM enables and status share it
   assign o_playing = run;
   assign o_sram_we = 1'b1;
   assign o_sram_ce = ~run;
   assign o_sram_oe = ~run;
   assign o_sram_lb = ~run;
   assign o_sram_ub = ~run;

   always_ff @(negedge i_BCLK or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         cnt         <= '0;
         shift       <= '0;
         lrc_prev    <= 1'b1;
         pause_pend  <= 1'b0;
         run         <= 1'b0;
         o_sram_addr <= '0;
         o_DACDAT    <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         lrc_prev <= i_DACLRC;
         o_done   <= 1'b0;
         if (i_stop) begin
            state      <= IDLE;
            cnt        <= '0;
            pause_pend <= 1'b0;
            run        <= 1'b0;
            o_DACDAT   <= 1'b0;
         end else begin
            if (i_pause && run)
               pause_pend <= 1'b1;
            case (state)
               IDLE: begin
                  o_DACDAT <= 1'b0;
                  if (i_start) begin
                     o_sram_addr <= i_start_addr;
                     if (i_start_addr == i_end_addr) begin
                        o_done <= 1'b1;
                     end else begin
                        state <= SYNC;
                        run   <= 1'b1;
                     end
                  end
               end
               SYNC: begin
                  if (fall) begin
                     shift    <= i_sram_data;
                     o_DACDAT <= i_sram_data[DATA_W-1];
                     cnt      <= CNT_W'(1);
                     state    <= SEND_L;
                  end else begin
                     o_DACDAT <= 1'b0;
                  end
               end
               SEND_L: begin
                  if (rise) begin
                     // codec restarted the frame early: replay this sample
                     o_DACDAT <= 1'b0;
                     state    <= SYNC;
                  end else if (last_bit) begin
                     o_DACDAT <= 1'b0;
                     state    <= WAIT_R;
                  end else begin
                     o_DACDAT <= shift[bit_idx];
                     cnt      <= cnt + 1'b1;
                  end
               end
               WAIT_R: begin
                  if (fall) begin
                     o_DACDAT <= 1'b0;
                     state    <= SYNC;
                  end else if (rise) begin
                     o_DACDAT <= shift[DATA_W-1];
                     cnt      <= CNT_W'(1);
                     state    <= SEND_R;
                  end else begin
                     o_DACDAT <= 1'b0;
                  end
               end
               SEND_R: begin
                  if (fall) begin
                     o_DACDAT <= 1'b0;
                     state    <= SYNC;
                  end else if (last_bit) begin
                     o_DACDAT <= 1'b0;
                     state    <= ADVANCE;
                  end else begin
                     o_DACDAT <= shift[bit_idx];
                     cnt      <= cnt + 1'b1;
                  end
               end
               ADVANCE: begin
                  o_DACDAT    <= 1'b0;
                  o_sram_addr <= addr_nxt;
                  if (addr_nxt == i_end_addr) begin
                     o_done     <= 1'b1;
                     pause_pend <= 1'b0;
                     run        <= 1'b0;
                     state      <= IDLE;
                  end else if (pause_pend) begin
                     run   <= 1'b0;
                     state <= PAUSED;
                  end else begin
                     state <= SYNC;
                  end
               end
               PAUSED: begin
                  o_DACDAT <= 1'b0;
                  if (i_pause) begin
                     pause_pend <= 1'b0;
                     run        <= 1'b1;
                     state      <= SYNC;
                  end
               end
               default: begin
                  o_DACDAT <= 1'b0;
                  run      <= 1'b0;
                  state    <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: stimulus queues expected channel words, a monitor deserialises DACDAT.
module tb_i2s_transmitter;

   logic        bclk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        stop = 1'b0;
   logic        lrc = 1'b1;
   logic [19:0] start_addr = '0;
   logic [19:0] end_addr = '0;
   logic [15:0] sram_data;
   logic [19:0] sram_addr;
   logic        sram_we, sram_ce, sram_oe, sram_lb, sram_ub;
   logic        dacdat, playing, done;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_end_cyc = 0;
   int cyc = 0;
   logic [15:0] exp_q[$];

   i2s_transmitter #(.DATA_W(16), .ADDR_W(20)) dut (
      .i_BCLK(bclk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
      .i_DACLRC(lrc), .i_start_addr(start_addr), .i_end_addr(end_addr),
      .i_sram_data(sram_data), .o_sram_addr(sram_addr), .o_sram_we(sram_we),
      .o_sram_ce(sram_ce), .o_sram_oe(sram_oe), .o_sram_lb(sram_lb), .o_sram_ub(sram_ub),
      .o_DACDAT(dacdat), .o_playing(playing), .o_done(done)
   );

   function automatic logic [15:0] mem_f(input logic [19:0] a);
      case (a)
         20'h00000: mem_f = 16'hA5C3;
         20'h00001: mem_f = 16'h8001;
         20'hFFFFF: mem_f = 16'hC0DE;
         default:   mem_f = {a[7:0], ~a[7:0]} ^ 16'h3C00;
      endcase
   endfunction

   assign sram_data = mem_f(sram_addr);

   initial forever #5 bclk = ~bclk;

   // codec: 64 BCLK per LRC period, changing on the BCLK rising edge
   initial forever begin
      repeat (32) @(posedge bclk);
      lrc = ~lrc;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push2(input logic [19:0] a);
      exp_q.push_back(mem_f(a));
      exp_q.push_back(mem_f(a));
   endtask

   // issue a start a few cycles into the LRC high half so SYNC precedes the next fall
   task automatic play(input logic [19:0] s, input logic [19:0] e);
      @(posedge lrc);
      repeat (2) @(posedge bclk);
      start_addr = s;
      end_addr   = e;
      start      = 1'b1;
      @(posedge bclk);
      start      = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int k = 0; k < 2000 && done_cnt < target; k++) @(posedge bclk);
      #2;
      chk(name, done_cnt, target);
   endtask

   task automatic wait_addr(input logic [19:0] a, input string name);
      for (int k = 0; k < 400 && sram_addr != a; k++) @(posedge bclk);
      #1;
      chk(name, sram_addr, a);
   endtask

   // monitor: a channel is the 16 samples following an LRC edge; a right channel only counts after a left
   initial begin : monitor
      logic       last_lrc;
      logic       have_left;
      logic       was_left;
      int         coll_n;
      logic [15:0] word;
      last_lrc  = 1'b1;
      have_left = 1'b0;
      was_left  = 1'b0;
      coll_n    = 0;
      word      = '0;
      forever begin
         @(posedge bclk);
         #1;
         cyc++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (coll_n > 0) begin
            if (!playing) begin
               coll_n    = 0;
               have_left = 1'b0;
            end else begin
               word = {word[14:0], dacdat};
               coll_n--;
               if (coll_n == 0) begin
                  last_end_cyc = cyc;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_channel", 32'(word), 32'hDEAD_BEEF);
                  end else begin
                     chk(was_left ? "left_word" : "right_word", 32'(word), 32'(exp_q.pop_front()));
                  end
                  have_left = was_left;
               end
            end
         end else if (lrc != last_lrc && playing) begin
            if (!lrc) begin
               coll_n   = 16;
               was_left = 1'b1;
            end else if (have_left) begin
               coll_n   = 16;
               was_left = 1'b0;
            end
         end
         if (!playing) have_left = 1'b0;
         last_lrc = lrc;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int d0;
      int nz;
      int bad_addr;

      // reset values
      #12;
      chk("rst_dacdat", 32'(dacdat), 0);
      chk("rst_addr", 32'(sram_addr), 0);
      chk("rst_we", 32'(sram_we), 1);
      chk("rst_ce", 32'(sram_ce), 1);
      chk("rst_oe", 32'(sram_oe), 1);
      chk("rst_lb", 32'(sram_lb), 1);
      chk("rst_ub", 32'(sram_ub), 1);
      chk("rst_playing", 32'(playing), 0);
      chk("rst_done", 32'(done), 0);
      @(posedge bclk);
      rst = 1'b0;

      // two samples from 0
      push2(20'h00000);
      push2(20'h00001);
      play(20'h00000, 20'h00002);
      wait_done(1, "t1_done_count");
      chk("t1_done_after_last_bit", 32'(done_cyc - last_end_cyc), 2);
      chk("t1_end_addr", 32'(sram_addr), 32'h2);
      chk("t1_idle", 32'(playing), 0);
      chk("t1_idle_ce", 32'(sram_ce), 1);

      // address wrap
      push2(20'hFFFFF);
      push2(20'h00000);
      play(20'hFFFFF, 20'h00001);
      wait_done(2, "t2_done_count");
      chk("t2_end_addr", 32'(sram_addr), 32'h1);

      // pause during sample 3 left channel, hold, then resume
      for (int a = 0; a < 4; a++) push2(20'(a));
      play(20'h00000, 20'h00010);
      wait_addr(20'h3, "t3_reach_addr3");
      @(negedge lrc);
      repeat (5) @(posedge bclk);
      pause = 1'b1;
      @(posedge bclk);
      pause = 1'b0;
      for (int k = 0; k < 300 && playing; k++) @(posedge bclk);
      chk("t3_paused", 32'(playing), 0);
      nz = 0;
      bad_addr = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge bclk);
         if (dacdat !== 1'b0 || playing !== 1'b0 || sram_ce !== 1'b1) nz++;
         if (sram_addr !== 20'h4) bad_addr++;
      end
      chk("t3_pause_quiet", 32'(nz), 0);
      chk("t3_pause_addr_held", 32'(bad_addr), 0);
      chk("t3_pause_addr", 32'(sram_addr), 32'h4);
      push2(20'h00004);
      pause = 1'b1;
      @(posedge bclk);
      pause = 1'b0;
      wait_addr(20'h5, "t3_resume_addr5");
      chk("t3_no_done", 32'(done_cnt), 2);
      stop = 1'b1;
      @(posedge bclk);
      stop = 1'b0;

      // stop and start together during the right channel
      exp_q.push_back(mem_f(20'h00020));
      play(20'h00020, 20'h00030);
      @(negedge lrc);
      @(posedge lrc);
      repeat (5) @(posedge bclk);
      stop  = 1'b1;
      start = 1'b1;
      @(posedge bclk);
      stop  = 1'b0;
      start = 1'b0;
      #1;
      chk("t4_dacdat", 32'(dacdat), 0);
      chk("t4_playing", 32'(playing), 0);
      chk("t4_ce", 32'(sram_ce), 1);
      repeat (100) @(posedge bclk);
      #2;
      chk("t4_no_done", 32'(done_cnt), 2);
      chk("t4_stays_idle", 32'(playing), 0);

      // empty window
      start_addr = 20'h00100;
      end_addr   = 20'h00100;
      @(posedge bclk);
      start = 1'b1;
      @(posedge bclk);
      start = 1'b0;
      #1;
      chk("t5_done_pulse", 32'(done), 1);
      chk("t5_playing", 32'(playing), 0);
      chk("t5_ce", 32'(sram_ce), 1);
      chk("t5_addr", 32'(sram_addr), 32'h100);
      @(posedge bclk);
      #1;
      chk("t5_done_one_cycle", 32'(done), 0);
      chk("t5_still_idle", 32'(playing), 0);

      // async reset in the middle of the left channel (cnt = 7)
      play(20'h00000, 20'h00002);
      @(negedge lrc);
      repeat (7) @(posedge bclk);
      #2;
      chk("t6_pre_playing", 32'(playing), 1);
      rst = 1'b1;
      #1;
      chk("t6_dacdat", 32'(dacdat), 0);
      chk("t6_addr", 32'(sram_addr), 0);
      chk("t6_ce", 32'(sram_ce), 1);
      chk("t6_oe", 32'(sram_oe), 1);
      chk("t6_playing", 32'(playing), 0);
      chk("t6_done", 32'(done), 0);
      @(posedge bclk);
      rst = 1'b0;
      repeat (80) @(posedge bclk);
      #2;
      chk("t6_after_idle", 32'(playing), 0);
      chk("t6_after_dacdat", 32'(dacdat), 0);

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
